// File: rtl/execute.sv
// Y86-64 execute stage: ALU result, branch/cmov condition, condition-code register and halt latch.
// valE, Cnd and exe_err are combinational; cc and halted update on the rising clock edge.
module execute #(
   parameter int unsigned WIDTH      = 64,
   parameter int unsigned STACK_STEP = 8,
   parameter logic [2:0]  CC_RESET   = 3'b100
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       icode,
   input  logic [3:0]       ifun,
   input  logic [WIDTH-1:0] valA,
   input  logic [WIDTH-1:0] valB,
   input  logic [WIDTH-1:0] valC,
   output logic [WIDTH-1:0] valE,
   output logic             Cnd,
   output logic [2:0]       cc,
   output logic             halted,
   output logic             exe_err
);

   localparam int unsigned MSB = WIDTH - 1;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_RRMOV  = 4'h2;
   localparam logic [3:0] I_IRMOV  = 4'h3;
   localparam logic [3:0] I_RMMOV  = 4'h4;
   localparam logic [3:0] I_MRMOV  = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSH   = 4'hA;
   localparam logic [3:0] I_POP    = 4'hB;

   localparam logic [WIDTH-1:0] STEP = WIDTH'(STACK_STEP);

   logic       new_zf;
   logic       new_sf;
   logic       new_of;
   logic       cc_load;
   logic       zf;
   logic       sf;
   logic       of;

   assign zf = cc[2];
   assign sf = cc[1];
   assign of = cc[0];

   // ALU, flag generation, condition evaluation and error detection
   always_comb begin
      valE    = '0;
      Cnd     = 1'b0;
      exe_err = 1'b0;
      new_of  = 1'b0;
      unique case (icode)
         I_RRMOV, I_JXX: begin
            if (ifun > 4'd6) begin
               exe_err = 1'b1;
            end else begin
               if (icode == I_RRMOV) valE = valA;
               case (ifun)
                  4'd0:    Cnd = 1'b1;
                  4'd1:    Cnd = (sf ^ of) | zf;
                  4'd2:    Cnd = sf ^ of;
                  4'd3:    Cnd = zf;
                  4'd4:    Cnd = !zf;
                  4'd5:    Cnd = !(sf ^ of);
                  4'd6:    Cnd = !(sf ^ of) && !zf;
                  default: Cnd = 1'b0;
               endcase
            end
         end
         I_IRMOV:          valE = valC;
         I_RMMOV, I_MRMOV: valE = valB + valC;
         I_OPQ: begin
            case (ifun)
               4'd0: begin
                  valE   = valB + valA;
                  new_of = (valA[MSB] == valB[MSB]) && (valE[MSB] != valA[MSB]);
               end
               4'd1: begin
                  valE   = valB - valA;
                  new_of = (valB[MSB] != valA[MSB]) && (valE[MSB] != valB[MSB]);
               end
               4'd2:    valE = valB & valA;
               4'd3:    valE = valB ^ valA;
               default: exe_err = 1'b1;
            endcase
         end
         I_CALL, I_PUSH:   valE = valB - STEP;
         I_RET, I_POP:     valE = valB + STEP;
         default:          valE = '0;
      endcase
   end

   assign new_zf  = (valE == '0);
   assign new_sf  = valE[MSB];
   assign cc_load = (icode == I_OPQ) && (ifun <= 4'd3) && !halted;

   // Condition codes: loaded only by a valid OPq while not halted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cc <= CC_RESET;
      end else if (cc_load) begin
         cc <= {new_zf, new_sf, new_of};
      end
   end

   // Halt latch: sticky until reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         halted <= 1'b0;
      end else if (icode == I_HALT) begin
         halted <= 1'b1;
      end
   end

endmodule
